// File: rtl/dcache_pkg.sv
// Shared types and address-slicing helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int INDEX_LO   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_t;

    function automatic int index_hi(input int index_bits);
        return index_bits + 1;
    endfunction

    function automatic int tag_lo(input int index_bits);
        return index_bits + 2;
    endfunction

    function automatic int tag_w(input int addr_w, input int index_bits);
        return addr_w - index_bits - 2;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid bits (clearable), tags and data words (not reset).
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int TAG_W      = 25,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_W-1:0]     wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

    // A write always leaves the line valid: it is either a refill or a hit update.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with
// same-cycle read hits and saturating hit/miss counters.
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int TAG_W = tag_w(ADDR_W, INDEX_BITS);
    localparam int IHI   = index_hi(INDEX_BITS);
    localparam int TLO   = tag_lo(INDEX_BITS);

    // Handshake: mem_rd_req/mem_wr_req are held high for the whole request and
    // the transfer completes in the cycle mem_ready is sampled high (ready may
    // arrive in the first request cycle); cpu_read/cpu_write are levels that
    // the pipeline holds while stall is high.
    state_t state, state_nxt;
    logic   done;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_W-1:0]      tag;
    logic [ADDR_W-1:0]     addr_aligned;
    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [DATA_W-1:0]     line_data;
    logic                  hit;
    logic                  wr_req_now;
    logic                  rd_req_now;
    logic                  arr_we;
    logic [DATA_W-1:0]     arr_wdata;

    assign index        = cpu_addr[IHI:INDEX_LO];
    assign tag          = cpu_addr[ADDR_W-1:TLO];
    assign addr_aligned = cpu_addr & ~ADDR_W'(3);
    assign hit          = line_valid && (line_tag == tag);
    // done hides a store the pipeline is still holding in its release cycle.
    assign wr_req_now   = cpu_write && !done;
    assign rd_req_now   = cpu_read && !cpu_write;

    assign arr_we    = rst && (((state == RD_MISS) && mem_ready) ||
                               ((state == IDLE) && wr_req_now && hit));
    assign arr_wdata = (state == RD_MISS) ? mem_rdata : cpu_wdata;

    dcache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk      (clk),
        .clr      (!rst),
        .rd_index (index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .we       (arr_we),
        .wr_index (index),
        .wr_tag   (tag),
        .wr_data  (arr_wdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == WR_THRU) && mem_ready;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_req_now) begin
                    state_nxt = WR_THRU;
                end else if (rd_req_now && !hit) begin
                    state_nxt = RD_MISS;
                end
            end
            RD_MISS, WR_THRU: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_rdata  = '0;
        if (rst) begin
            mem_addr  = addr_aligned;
            mem_wdata = cpu_wdata;
            cpu_rdata = line_data;
            case (state)
                IDLE:    stall = wr_req_now || (rd_req_now && !hit);
                RD_MISS: begin
                    stall      = 1'b1;
                    mem_rd_req = 1'b1;
                end
                WR_THRU: begin
                    stall      = 1'b1;
                    mem_wr_req = 1'b1;
                end
                default: stall = 1'b0;
            endcase
        end
    end

    // Only read lookups in IDLE are counted; the post-refill hit counts too.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if ((state == IDLE) && rd_req_now) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            end else begin
                if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Randomized bench for dcache_dm against a memory-coherence reference model.
module tb_dcache_dm;

    localparam int IB    = 4;
    localparam int LINES = 16;
    localparam int CW    = 4;
    localparam int CMAX  = 15;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    dcache_dm #(
        .INDEX_BITS (IB),
        .ADDR_W     (32),
        .DATA_W     (32),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_rdata  (cpu_rdata),
        .stall      (stall),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // reference model: backing memory plus which words the cache holds
    logic [31:0] mem_model [logic [29:0]];
    logic        m_valid [LINES];
    logic [25:0] m_tag   [LINES];
    int          m_hits;
    int          m_misses;
    logic [31:0] exp_q [$];

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic get_word(input logic [31:0] addr, output logic [31:0] w);
        if (!mem_model.exists(addr[31:2])) mem_model[addr[31:2]] = $urandom;
        w = mem_model[addr[31:2]];
    endtask

    // driver tasks
    task automatic do_read(input logic [31:0] addr, input int d);
        int          idx;
        logic [25:0] t;
        logic        hit_exp;
        logic [31:0] word;
        int          stalls, rd_cyc, wr_cyc;
        logic        finished;
        idx      = int'(addr[5:2]);
        t        = addr[31:6];
        hit_exp  = m_valid[idx] && (m_tag[idx] == t);
        get_word(addr, word);
        exp_q.push_back(word);
        cpu_addr  = addr;
        cpu_read  = 1'b1;
        cpu_write = 1'b0;
        stalls = 0; rd_cyc = 0; wr_cyc = 0; finished = 1'b0;
        for (int c = 0; c < 40 && !finished; c++) begin
            @(negedge clk);
            if (!stall) begin
                finished = 1'b1;
            end else begin
                stalls++;
                if (mem_rd_req) begin
                    rd_cyc++;
                    check("rd_addr", mem_addr, addr & ~32'h3);
                    if (rd_cyc == d + 1) begin
                        mem_rdata = word;
                        mem_ready = 1'b1;
                    end
                end
                if (mem_wr_req) wr_cyc++;
                @(posedge clk); #1;
                mem_ready = 1'b0;
            end
        end
        check("rd_done", {31'd0, finished}, 32'd1);
        check("rd_data", cpu_rdata, exp_q.pop_front());
        check("rd_stalls", stalls, hit_exp ? 0 : d + 2);
        check("rd_reqs", rd_cyc, hit_exp ? 0 : d + 1);
        check("rd_no_wr", wr_cyc, 0);
        @(posedge clk); #1;
        cpu_read = 1'b0;
        if (!hit_exp) begin
            m_misses    = sat_inc(m_misses);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = t;
        end
        m_hits = sat_inc(m_hits);
        check("hit_count", {28'd0, hit_count}, m_hits);
        check("miss_count", {28'd0, miss_count}, m_misses);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input int d, input logic with_read);
        int   stalls, rd_cyc, wr_cyc;
        logic finished;
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_write = 1'b1;
        cpu_read  = with_read;
        stalls = 0; rd_cyc = 0; wr_cyc = 0; finished = 1'b0;
        for (int c = 0; c < 40 && !finished; c++) begin
            @(negedge clk);
            if (!stall) begin
                finished = 1'b1;
            end else begin
                stalls++;
                if (mem_wr_req) begin
                    wr_cyc++;
                    check("wr_addr", mem_addr, addr & ~32'h3);
                    check("wr_data", mem_wdata, data);
                    if (wr_cyc == d + 1) mem_ready = 1'b1;
                end
                if (mem_rd_req) rd_cyc++;
                @(posedge clk); #1;
                mem_ready = 1'b0;
            end
        end
        check("wr_done", {31'd0, finished}, 32'd1);
        check("wr_stalls", stalls, d + 2);
        check("wr_reqs", wr_cyc, d + 1);
        check("wr_no_rd", rd_cyc, 0);
        @(posedge clk); #1;
        cpu_write = 1'b0;
        cpu_read  = 1'b0;
        mem_model[addr[31:2]] = data;
        check("hit_count", {28'd0, hit_count}, m_hits);
        check("miss_count", {28'd0, miss_count}, m_misses);
    endtask

    task automatic do_idle(input logic ready_noise);
        mem_ready = ready_noise;
        @(negedge clk);
        check("idle_stall", {31'd0, stall}, 32'd0);
        check("idle_reqs", {30'd0, mem_rd_req, mem_wr_req}, 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
    endtask

    // main sequence and final report
    initial begin
        logic [25:0] rt;
        logic [3:0]  ri;
        logic [1:0]  ro;
        logic [31:0] ra;
        int          op;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst       = 1'b0;
        cpu_addr  = 32'h1234_5678;
        cpu_wdata = 32'hA5A5_A5A5;
        cpu_read  = 1'b1;
        cpu_write = 1'b0;
        mem_rdata = 32'h0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_rd_req", {31'd0, mem_rd_req}, 32'd0);
        check("rst_wr_req", {31'd0, mem_wr_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_hits", {28'd0, hit_count}, 32'd0);
        check("rst_misses", {28'd0, miss_count}, 32'd0);
        @(posedge clk); #1;
        rst      = 1'b1;
        cpu_read = 1'b0;
        do_idle(1'b1);

        // directed scenarios
        mem_model[30'h10] = 32'hDEAD_BEEF;
        do_read(32'h0000_0040, 3);
        do_read(32'h0000_0040, 0);
        do_write(32'h0000_0040, 32'h1234_5678, 2, 1'b0);
        do_read(32'h0000_0040, 0);
        do_write(32'h0000_0080, 32'hCAFE_F00D, 1, 1'b0);
        do_read(32'h0000_0040, 0);
        do_read(32'h0000_0C40, 2);
        do_read(32'h0000_0040, 1);
        do_write(32'h0000_0044, 32'h0BAD_CAFE, 0, 1'b1);
        do_read(32'h0000_0080, 0);

        // reset in the middle of a refill, then a late mem_ready
        cpu_addr = 32'h0000_0200;
        cpu_read = 1'b1;
        @(negedge clk);
        check("mid_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rd_req", {31'd0, mem_rd_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstlo_stall", {31'd0, stall}, 32'd0);
        check("rstlo_rd_req", {31'd0, mem_rd_req}, 32'd0);
        check("rstlo_addr", mem_addr, 32'd0);
        check("rstlo_rdata", cpu_rdata, 32'd0);
        @(posedge clk); #1;
        rst       = 1'b1;
        cpu_read  = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        mem_ready = 1'b1;
        @(negedge clk);
        check("late_ready_stall", {31'd0, stall}, 32'd0);
        check("late_ready_req", {31'd0, mem_rd_req}, 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        model_reset();
        check("post_rst_hits", {28'd0, hit_count}, 32'd0);
        check("post_rst_misses", {28'd0, miss_count}, 32'd0);
        do_read(32'h0000_0040, 1);
        do_read(32'h0000_0200, 0);

        // randomized traffic over a few tags so hits, conflicts and saturation occur
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            rt = ($urandom_range(0, 7) == 0) ? 26'h3FF_FFFF : 26'($urandom_range(0, 3));
            ri = 4'($urandom_range(0, 15));
            ro = 2'($urandom_range(0, 3));
            ra = {rt, ri, ro};
            if (op <= 5) begin
                do_read(ra, $urandom_range(0, 3));
            end else if (op <= 8) begin
                do_write(ra, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end else begin
                do_idle(1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
